// File: rtl/eedc_encode_tx.sv
// EEDC 7->11 transmit encoder: two-stage elastic pipeline with optional single-bit
// error injection and saturating codeword/injection counters.
module eedc_encode_tx #(
   parameter int CNT_W      = 16,
   parameter bit INJ_ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_data,
   input  logic             inj_en,
   input  logic [3:0]       inj_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      out_codeword,
   output logic             out_injected,
   output logic [CNT_W-1:0] cw_count,
   output logic [CNT_W-1:0] inj_count
);

   logic        s1_v;
   logic [6:0]  s1_data;
   logic [3:0]  s1_chk;
   logic        s1_inj_en;
   logic [3:0]  s1_inj_pos;

   logic        s2_take;
   logic        in_fire;
   logic        out_fire;
   logic [3:0]  chk;
   logic        inj_hit;
   logic [10:0] flip_mask;

   // Check bits cw[3:1]; cw[0] makes the full 11-bit word even parity.
   always_comb begin
      chk    = '0;
      chk[3] = in_data[0] ^ in_data[2] ^ in_data[4] ^ in_data[6];
      chk[2] = in_data[0] ^ in_data[1] ^ in_data[4] ^ in_data[5];
      chk[1] = in_data[0] ^ in_data[1] ^ in_data[2] ^ in_data[3];
      chk[0] = (^in_data) ^ chk[3] ^ chk[2] ^ chk[1];
   end

   assign s2_take  = !out_valid || out_ready;
   assign in_ready = !s1_v || s2_take;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   assign inj_hit   = INJ_ENABLE && s1_inj_en && (s1_inj_pos <= 4'd10);
   assign flip_mask = inj_hit ? (11'd1 << s1_inj_pos) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v       <= 1'b0;
         s1_data    <= '0;
         s1_chk     <= '0;
         s1_inj_en  <= 1'b0;
         s1_inj_pos <= '0;
      end else if (in_fire) begin
         s1_v       <= 1'b1;
         s1_data    <= in_data;
         s1_chk     <= chk;
         s1_inj_en  <= inj_en;
         s1_inj_pos <= inj_pos;
      end else if (s2_take) begin
         s1_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_codeword <= '0;
         out_injected <= 1'b0;
      end else if (s2_take) begin
         out_valid <= s1_v;
         if (s1_v) begin
            out_codeword <= {s1_data, s1_chk} ^ flip_mask;
            out_injected <= inj_hit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw_count  <= '0;
         inj_count <= '0;
      end else if (out_fire) begin
         if (cw_count != '1)
            cw_count <= cw_count + 1'b1;
         if (out_injected && (inj_count != '1))
            inj_count <= inj_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_eedc_encode_tx.sv
// Directed bench for eedc_encode_tx; counters narrowed to 4 bits so saturation is reachable.
module tb_eedc_encode_tx;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    in_data;
   logic          inj_en;
   logic [3:0]    inj_pos;
   logic          out_valid;
   logic          out_ready;
   logic [10:0]   out_codeword;
   logic          out_injected;
   logic [CW-1:0] cw_count;
   logic [CW-1:0] inj_count;

   int tests = 0;
   int fails = 0;

   eedc_encode_tx #(.CNT_W(CW), .INJ_ENABLE(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .inj_en       (inj_en),
      .inj_pos      (inj_pos),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_codeword (out_codeword),
      .out_injected (out_injected),
      .cw_count     (cw_count),
      .inj_count    (inj_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_codeword", 32'(out_codeword), 32'h000);
      chk("rst_injected", 32'(out_injected), 32'd0);
      chk("rst_cw_count", 32'(cw_count), 32'd0);
      chk("rst_inj_count", 32'(inj_count), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 1: single word, latency
      in_valid = 1'b1; in_data = 7'h59;
      tick();
      in_valid = 1'b0;
      chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_cw", 32'(out_codeword), 32'h599);
      chk("t1_inj", 32'(out_injected), 32'd0);
      tick();
      chk("t1_drained", 32'(out_valid), 32'd0);
      chk("t1_cw_count", 32'(cw_count), 32'd1);

      // 2: back-to-back, no bubble
      in_valid = 1'b1; in_data = 7'h00;
      tick();
      in_data = 7'h7F;
      tick();
      in_valid = 1'b0;
      chk("t2_v0", 32'(out_valid), 32'd1);
      chk("t2_cw0", 32'(out_codeword), 32'h000);
      tick();
      chk("t2_v1", 32'(out_valid), 32'd1);
      chk("t2_cw1", 32'(out_codeword), 32'h7F1);
      tick();
      chk("t2_drained", 32'(out_valid), 32'd0);
      chk("t2_cw_count", 32'(cw_count), 32'd3);

      // 3: injection at positions 10, 4, 12
      in_valid = 1'b1; in_data = 7'h59; inj_en = 1'b1; inj_pos = 4'd10;
      tick();
      inj_pos = 4'd4;
      tick();
      chk("t3_cw_pos10", 32'(out_codeword), 32'h199);
      chk("t3_inj_pos10", 32'(out_injected), 32'd1);
      inj_pos = 4'd12;
      tick();
      in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
      chk("t3_cw_pos4", 32'(out_codeword), 32'h589);
      chk("t3_inj_pos4", 32'(out_injected), 32'd1);
      tick();
      chk("t3_cw_pos12", 32'(out_codeword), 32'h599);
      chk("t3_inj_pos12", 32'(out_injected), 32'd0);
      tick();
      chk("t3_cw_count", 32'(cw_count), 32'd6);
      chk("t3_inj_count", 32'(inj_count), 32'd2);

      // 4: backpressure with three words
      out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h11;
      #1 chk("t4_rdy_empty", 32'(in_ready), 32'd1);
      tick();
      chk("t4_rdy_s1only", 32'(in_ready), 32'd1);
      in_data = 7'h22;
      tick();
      in_data = 7'h33;
      for (int i = 0; i < 3; i++) begin
         chk("t4_rdy_full", 32'(in_ready), 32'd0);
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_cw", 32'(out_codeword), 32'h113);
         tick();
      end
      chk("t4_hold_count", 32'(cw_count), 32'd6);
      out_ready = 1'b1;
      #1 chk("t4_rdy_release", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t4_w1", 32'(out_codeword), 32'h223);
      tick();
      chk("t4_w2_valid", 32'(out_valid), 32'd1);
      chk("t4_w2", 32'(out_codeword), 32'h330);
      tick();
      chk("t4_drained", 32'(out_valid), 32'd0);
      chk("t4_cw_count", 32'(cw_count), 32'd9);

      // 5: async reset with both stages full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h44;
      tick();
      in_data = 7'h55;
      tick();
      in_valid = 1'b0;
      chk("t5_full_valid", 32'(out_valid), 32'd1);
      chk("t5_full_rdy", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_cw", 32'(out_codeword), 32'h000);
      chk("t5_rst_count", 32'(cw_count), 32'd0);
      chk("t5_rst_inj", 32'(inj_count), 32'd0);
      tick();
      rst_n = 1'b1; out_ready = 1'b1;
      tick();
      chk("t5_rdy", 32'(in_ready), 32'd1);
      chk("t5_no_stale0", 32'(out_valid), 32'd0);
      tick();
      chk("t5_no_stale1", 32'(out_valid), 32'd0);
      chk("t5_count_zero", 32'(cw_count), 32'd0);

      // 6: saturation at 4'hF for both counters
      in_valid = 1'b1; in_data = 7'h7F; inj_en = 1'b1; inj_pos = 4'd0;
      for (int i = 0; i < 14; i++) tick();
      in_valid = 1'b0;
      chk("t6_stream_cw", 32'(out_codeword), 32'h7F0);
      tick(); tick();
      chk("t6_cw_count_14", 32'(cw_count), 32'd14);
      chk("t6_inj_count_14", 32'(inj_count), 32'd14);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0; inj_en = 1'b0;
      tick(); tick();
      chk("t6_cw_count_sat", 32'(cw_count), 32'd15);
      chk("t6_inj_count_sat", 32'(inj_count), 32'd15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
